// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   state_e    - controller state encoding (RUN, MEM_WAIT, FLUSH)
//   RegAddrW   - register-file address width
//   InstAddrW  - instruction address width
//   Asserted / Deasserted - control-level constants
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW  = 5;
  localparam int unsigned InstAddrW = 32;

  localparam logic Asserted   = 1'b1;
  localparam logic Deasserted = 1'b0;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator.
// Flags when the instruction in EX is a load whose destination is a source
// register actually read by the instruction in ID.
// Ports:
//   rs1_addr_i / rs1_re_i  - ID rs1 address and read enable
//   rs2_addr_i / rs2_re_i  - ID rs2 address and read enable
//   ex_mem_read_i          - EX instruction is a load
//   ex_reg_write_i         - EX instruction writes a register
//   ex_write_addr_i        - EX destination register
//   load_use_o             - load-use hazard present this cycle
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [RegAddrW-1:0] rs1_addr_i,
  input  logic                rs1_re_i,
  input  logic [RegAddrW-1:0] rs2_addr_i,
  input  logic                rs2_re_i,
  input  logic                ex_mem_read_i,
  input  logic                ex_reg_write_i,
  input  logic [RegAddrW-1:0] ex_write_addr_i,
  output logic                load_use_o
);

  logic producer;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    producer   = ex_mem_read_i && ex_reg_write_i && (ex_write_addr_i != '0);
    rs1_hit    = rs1_re_i && (rs1_addr_i == ex_write_addr_i);
    rs2_hit    = rs2_re_i && (rs2_addr_i == ex_write_addr_i);
    load_use_o = producer && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the pc, if_id, id_ex and ex_mem registers.
// - Load-use hazard: one-cycle bubble into id_ex while pc and if_id hold.
// - Data memory not ready: whole pipeline frozen, with a timeout watchdog.
// - Taken branch in MEM: flush, then registered redirect plus a second flush.
// - Saturating count of cycles in which the PC was held.
// Ports:
//   clk, rst                     - clock, synchronous active-low reset
//   id_rs1_*/id_rs2_*            - ID source registers and read enables
//   ex_mem_read_i/ex_reg_write_i - EX instruction is a load / writes a register
//   ex_write_addr_i              - EX destination register
//   mem_access_i/dmem_ready_i    - MEM data access and its completion
//   mem_branch_taken_i/_target_i - MEM branch resolution and target
//   *_stall_o/*_flush_o          - per-register hold / bubble controls
//   pc_redirect_o/pc_target_o    - PC redirect and its registered address
//   stall_cycles_o               - saturating stall-cycle count
//   err_timeout_o                - sticky memory timeout flag
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RegAddrW-1:0]  id_rs1_addr_i,
  input  logic                 id_rs1_re_i,
  input  logic [RegAddrW-1:0]  id_rs2_addr_i,
  input  logic                 id_rs2_re_i,
  input  logic                 ex_mem_read_i,
  input  logic                 ex_reg_write_i,
  input  logic [RegAddrW-1:0]  ex_write_addr_i,
  input  logic                 mem_access_i,
  input  logic                 dmem_ready_i,
  input  logic                 mem_branch_taken_i,
  input  logic [InstAddrW-1:0] mem_branch_target_i,
  output logic                 pc_stall_o,
  output logic                 if_id_stall_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_stall_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_stall_o,
  output logic                 ex_mem_flush_o,
  output logic                 pc_redirect_o,
  output logic [InstAddrW-1:0] pc_target_o,
  output logic [CNT_W-1:0]     stall_cycles_o,
  output logic                 err_timeout_o
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [InstAddrW-1:0] pc_target_q, pc_target_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     wait_inc;
  logic                 err_q, err_d;
  logic                 load_use;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .rs1_addr_i      (id_rs1_addr_i),
    .rs1_re_i        (id_rs1_re_i),
    .rs2_addr_i      (id_rs2_addr_i),
    .rs2_re_i        (id_rs2_re_i),
    .ex_mem_read_i   (ex_mem_read_i),
    .ex_reg_write_i  (ex_reg_write_i),
    .ex_write_addr_i (ex_write_addr_i),
    .load_use_o      (load_use)
  );

  always_comb begin
    pc_stall_o     = Deasserted;
    if_id_stall_o  = Deasserted;
    if_id_flush_o  = Deasserted;
    id_ex_stall_o  = Deasserted;
    id_ex_flush_o  = Deasserted;
    ex_mem_stall_o = Deasserted;
    ex_mem_flush_o = Deasserted;
    pc_redirect_o  = Deasserted;
    state_d        = state_q;
    pc_target_d    = pc_target_q;
    wait_cnt_d     = wait_cnt_q;
    wait_inc       = wait_cnt_q + CNT_W'(1);
    err_d          = err_q;

    // Control outputs stay quiet during reset; the registers reset on the edge.
    if (rst) begin
      unique case (state_q)
        StRun: begin
          if (mem_access_i && !dmem_ready_i) begin
            pc_stall_o     = Asserted;
            if_id_stall_o  = Asserted;
            id_ex_stall_o  = Asserted;
            ex_mem_stall_o = Asserted;
            state_d        = StMemWait;
          end else if (mem_branch_taken_i) begin
            if_id_flush_o  = Asserted;
            id_ex_flush_o  = Asserted;
            ex_mem_flush_o = Asserted;
            pc_target_d    = mem_branch_target_i;
            state_d        = StFlush;
          end else if (load_use) begin
            // The bubble moves the load on, so the hazard clears next cycle.
            pc_stall_o    = Asserted;
            if_id_stall_o = Asserted;
            id_ex_flush_o = Asserted;
          end
        end
        StMemWait: begin
          if (dmem_ready_i) begin
            wait_cnt_d = '0;
            state_d    = StRun;
          end else begin
            pc_stall_o     = Asserted;
            if_id_stall_o  = Asserted;
            id_ex_stall_o  = Asserted;
            ex_mem_stall_o = Asserted;
            if (wait_cnt_q >= TimeoutCnt) begin
              err_d = Asserted;
            end else begin
              wait_cnt_d = wait_inc;
              if (wait_inc == TimeoutCnt) begin
                err_d = Asserted;
              end
            end
          end
        end
        StFlush: begin
          // Second flush kills the wrong-path fetch and decode behind the redirect.
          pc_redirect_o = Asserted;
          if_id_flush_o = Asserted;
          id_ex_flush_o = Asserted;
          state_d       = StRun;
        end
        default: state_d = StRun;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StRun;
      pc_target_q <= '0;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_target_q <= pc_target_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pc_target_o    = pc_target_q;
  assign stall_cycles_o = stall_cnt_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a behavioural model produces the
// expected outputs for each driven cycle into a scoreboard queue, and a monitor
// compares them against the DUT on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW    = 16;
  localparam int unsigned Timeout = 8;

  // Bit positions inside the packed flag vector.
  localparam int FPcStall    = 7;
  localparam int FIfIdStall  = 6;
  localparam int FIfIdFlush  = 5;
  localparam int FIdExStall  = 4;
  localparam int FIdExFlush  = 3;
  localparam int FExMemStall = 2;
  localparam int FExMemFlush = 1;
  localparam int FRedirect   = 0;

  typedef struct packed {
    logic        rst;
    logic        rs1_re;
    logic [4:0]  rs1;
    logic        rs2_re;
    logic [4:0]  rs2;
    logic        ld;
    logic        wr;
    logic [4:0]  wa;
    logic        mem_acc;
    logic        rdy;
    logic        taken;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [7:0]      flags;
    logic [31:0]     target;
    logic [CntW-1:0] stalls;
    logic            err;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  v;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_addr_i = '0;
  logic        id_rs1_re_i = 1'b0;
  logic [4:0]  id_rs2_addr_i = '0;
  logic        id_rs2_re_i = 1'b0;
  logic        ex_mem_read_i = 1'b0;
  logic        ex_reg_write_i = 1'b0;
  logic [4:0]  ex_write_addr_i = '0;
  logic        mem_access_i = 1'b0;
  logic        dmem_ready_i = 1'b0;
  logic        mem_branch_taken_i = 1'b0;
  logic [31:0] mem_branch_target_i = '0;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_stall_o;
  logic        id_ex_flush_o;
  logic        ex_mem_stall_o;
  logic        ex_mem_flush_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic [CntW-1:0] stall_cycles_o;
  logic        err_timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  sb_item_t sb[$];

  // Model state: m_* is the state seen during the current cycle, n_* what the
  // coming rising edge will load.
  int              m_state = 0, n_state = 0;  // 0 run, 1 mem wait, 2 flush
  logic [31:0]     m_target = '0, n_target = '0;
  logic [CntW-1:0] m_stalls = '0, n_stalls = '0;
  int unsigned     m_wait = 0, n_wait = 0;
  logic            m_err = 1'b0, n_err = 1'b0;

  pipe_hazard_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_rs1_addr_i       (id_rs1_addr_i),
    .id_rs1_re_i         (id_rs1_re_i),
    .id_rs2_addr_i       (id_rs2_addr_i),
    .id_rs2_re_i         (id_rs2_re_i),
    .ex_mem_read_i       (ex_mem_read_i),
    .ex_reg_write_i      (ex_reg_write_i),
    .ex_write_addr_i     (ex_write_addr_i),
    .mem_access_i        (mem_access_i),
    .dmem_ready_i        (dmem_ready_i),
    .mem_branch_taken_i  (mem_branch_taken_i),
    .mem_branch_target_i (mem_branch_target_i),
    .pc_stall_o          (pc_stall_o),
    .if_id_stall_o       (if_id_stall_o),
    .if_id_flush_o       (if_id_flush_o),
    .id_ex_stall_o       (id_ex_stall_o),
    .id_ex_flush_o       (id_ex_flush_o),
    .ex_mem_stall_o      (ex_mem_stall_o),
    .ex_mem_flush_o      (ex_mem_flush_o),
    .pc_redirect_o       (pc_redirect_o),
    .pc_target_o         (pc_target_o),
    .stall_cycles_o      (stall_cycles_o),
    .err_timeout_o       (err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // One clock cycle: commit the model, drive the inputs, queue the expectation.
  task automatic step(input string tag, input stim_t s);
    exp_t     e;
    sb_item_t it;
    logic     lu;
    logic [7:0] fl;
    @(posedge clk);
    m_state  = n_state;
    m_target = n_target;
    m_stalls = n_stalls;
    m_wait   = n_wait;
    m_err    = n_err;
    #1;
    rst                 = s.rst;
    id_rs1_re_i         = s.rs1_re;
    id_rs1_addr_i       = s.rs1;
    id_rs2_re_i         = s.rs2_re;
    id_rs2_addr_i       = s.rs2;
    ex_mem_read_i       = s.ld;
    ex_reg_write_i      = s.wr;
    ex_write_addr_i     = s.wa;
    mem_access_i        = s.mem_acc;
    dmem_ready_i        = s.rdy;
    mem_branch_taken_i  = s.taken;
    mem_branch_target_i = s.tgt;

    lu = s.ld && s.wr && (s.wa != 5'd0) &&
         ((s.rs1_re && (s.rs1 == s.wa)) || (s.rs2_re && (s.rs2 == s.wa)));
    fl       = '0;
    n_state  = m_state;
    n_target = m_target;
    n_stalls = m_stalls;
    n_wait   = m_wait;
    n_err    = m_err;
    if (!s.rst) begin
      n_state  = 0;
      n_target = '0;
      n_stalls = '0;
      n_wait   = 0;
      n_err    = 1'b0;
    end else begin
      if (m_state == 0) begin
        if (s.mem_acc && !s.rdy) begin
          fl[FPcStall] = 1; fl[FIfIdStall] = 1; fl[FIdExStall] = 1; fl[FExMemStall] = 1;
          n_state = 1;
        end else if (s.taken) begin
          fl[FIfIdFlush] = 1; fl[FIdExFlush] = 1; fl[FExMemFlush] = 1;
          n_target = s.tgt;
          n_state  = 2;
        end else if (lu) begin
          fl[FPcStall] = 1; fl[FIfIdStall] = 1; fl[FIdExFlush] = 1;
        end
      end else if (m_state == 1) begin
        if (s.rdy) begin
          n_wait  = 0;
          n_state = 0;
        end else begin
          fl[FPcStall] = 1; fl[FIfIdStall] = 1; fl[FIdExStall] = 1; fl[FExMemStall] = 1;
          if (m_wait < Timeout) n_wait = m_wait + 1;
          if (n_wait >= Timeout) n_err = 1'b1;
        end
      end else begin
        fl[FRedirect] = 1; fl[FIfIdFlush] = 1; fl[FIdExFlush] = 1;
        n_state = 0;
      end
      if (fl[FPcStall] && (m_stalls != '1)) n_stalls = m_stalls + 1'b1;
    end

    e.flags  = fl;
    e.target = m_target;
    e.stalls = m_stalls;
    e.err    = m_err;
    it.tag   = tag;
    it.v     = e;
    sb.push_back(it);
  endtask

  // Monitor: compare queued expectations away from the rising edge.
  initial begin
    sb_item_t it;
    logic [7:0] got_fl;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        got_fl = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                  id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o, pc_redirect_o};
        check({it.tag, ".flags"}, 64'(got_fl), 64'(it.v.flags));
        check({it.tag, ".target"}, 64'(pc_target_o), 64'(it.v.target));
        check({it.tag, ".stalls"}, 64'(stall_cycles_o), 64'(it.v.stalls));
        check({it.tag, ".err"}, 64'(err_timeout_o), 64'(it.v.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;

    // Reset with a taken branch pending: nothing may leak out.
    s = idle(); s.rst = 1'b0; s.taken = 1'b1; s.tgt = 32'hdead_beef;
    step("rst0", s);
    step("rst1", s);
    step("quiet0", idle());
    step("quiet1", idle());

    // Load-use on rs2, then the same with x0 as destination.
    s = idle(); s.ld = 1; s.wr = 1; s.wa = 5'd5; s.rs2_re = 1; s.rs2 = 5'd5;
    step("lu_rs2", s);
    step("lu_after", idle());
    s.wa = 5'd0; s.rs2 = 5'd0;
    step("lu_x0", s);
    s = idle(); s.ld = 1; s.wr = 1; s.wa = 5'd7; s.rs1_re = 1; s.rs1 = 5'd7;
    step("lu_rs1", s);
    s.rs1_re = 0;
    step("lu_no_re", s);
    s.rs1_re = 1; s.ld = 0;
    step("lu_not_load", s);

    // Taken branch: flush, redirect + flush, quiet.
    s = idle(); s.taken = 1; s.tgt = 32'h0000_0100;
    step("br_t0", s);
    step("br_t1", idle());
    step("br_t2", idle());

    // Four-cycle memory wait.
    s = idle(); s.mem_acc = 1;
    repeat (4) step("mw", s);
    s.rdy = 1;
    step("mw_rdy", s);
    step("mw_done", idle());

    // Timeout: err rises after Timeout wait cycles and stays until reset.
    s = idle(); s.mem_acc = 1;
    for (int i = 0; i < 12; i++) step($sformatf("to%0d", i), s);
    s.rdy = 1;
    step("to_rdy", s);
    step("to_hold0", idle());
    step("to_hold1", idle());
    s = idle(); s.rst = 0;
    step("to_rst", s);
    step("to_clr", idle());

    // Memory wait and load-use together.
    s = idle(); s.mem_acc = 1; s.ld = 1; s.wr = 1; s.wa = 5'd3; s.rs1_re = 1; s.rs1 = 5'd3;
    step("mw_lu", s);
    s.rdy = 1;
    step("mw_lu_rdy", s);
    step("mw_lu_idle", idle());

    // Branch and load-use together.
    s = idle(); s.taken = 1; s.tgt = 32'h0000_0200; s.ld = 1; s.wr = 1; s.wa = 5'd9;
    s.rs2_re = 1; s.rs2 = 5'd9;
    step("br_lu0", s);
    step("br_lu1", idle());
    step("br_lu2", idle());

    // Reset in FLUSH and in MEM_WAIT.
    s = idle(); s.taken = 1; s.tgt = 32'h0000_0300;
    step("brr0", s);
    s = idle(); s.rst = 0;
    step("brr1", s);
    step("brr2", idle());
    s = idle(); s.mem_acc = 1;
    step("mwr0", s);
    step("mwr1", s);
    s.rst = 0;
    step("mwr2", s);
    step("mwr3", idle());

    // Random traffic over small register ranges to hit dependencies often.
    for (int i = 0; i < 300; i++) begin
      s         = '0;
      s.rst     = ($urandom_range(0, 39) != 0);
      s.rs1_re  = 1'($urandom_range(0, 1));
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2_re  = 1'($urandom_range(0, 1));
      s.rs2     = 5'($urandom_range(0, 3));
      s.ld      = 1'($urandom_range(0, 1));
      s.wr      = 1'($urandom_range(0, 1));
      s.wa      = 5'($urandom_range(0, 3));
      s.mem_acc = ($urandom_range(0, 3) == 0);
      s.rdy     = ($urandom_range(0, 2) != 0);
      s.taken   = ($urandom_range(0, 7) == 0);
      s.tgt     = $urandom;
      step($sformatf("rnd%0d", i), s);
    end
    step("end", idle());

    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
